// File: rtl/fractal_sync_pkg.sv
// Shared types and defaults for the FractalSync CU-side arbiter.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fsync_arb_state_e;

  localparam int unsigned FSYNC_ARB_TIMEOUT = 1024;

endpackage

// File: rtl/fractal_sync_cu_arbiter_if.sv
// Network-side FractalSync port: sync/aggr/id out, wake/error with lvl/id back.
interface fractal_sync_cu_arbiter_if #(
  parameter int AGGR_W = 3,
  parameter int LVL_W  = 1,
  parameter int ID_W   = 2
);

  logic              fsync_sync_o;
  logic [AGGR_W-1:0] fsync_aggr_o;
  logic [ID_W-1:0]   fsync_id_o;
  logic              fsync_wake_i;
  logic [LVL_W-1:0]  fsync_lvl_i;
  logic [ID_W-1:0]   fsync_id_i;
  logic              fsync_error_i;

  modport master (
    output fsync_sync_o, fsync_aggr_o, fsync_id_o,
    input  fsync_wake_i, fsync_lvl_i, fsync_id_i, fsync_error_i
  );

  modport slave (
    input  fsync_sync_o, fsync_aggr_o, fsync_id_o,
    output fsync_wake_i, fsync_lvl_i, fsync_id_i, fsync_error_i
  );

endinterface

// File: rtl/fractal_sync_rr_arbiter.sv
// Round-robin picker: first valid requester at or after the pointer, wrapping.
// The pointer moves to one past the served requester when an update is signalled.
module fractal_sync_rr_arbiter
  import fractal_sync_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] i_valid,
  input  logic             i_upd_en,
  input  logic [PTR_W-1:0] i_upd_idx,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_found
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;

  // Pointer advance wraps at N_REQ; with a single requester it stays at 0.
  always_comb begin
    w_ptr_next = '0;
    if (int'(i_upd_idx) + 1 < N_REQ) begin
      w_ptr_next = i_upd_idx + 1'b1;
    end
  end

  // Pointer register, updated only when the owner's response is delivered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (i_upd_en) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Scan from the pointer and take the first valid index.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      automatic int               k  = (int'(r_ptr) + i) % N_REQ;
      automatic logic [PTR_W-1:0] kk = PTR_W'(k);
      if (!o_found && i_valid[kk]) begin
        o_found = 1'b1;
        o_idx   = kk;
      end
    end
    if (o_found) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fractal_sync_cu_arbiter.sv
// Shares one FractalSync tree port between N_REQ local requesters: grants one,
// pulses its barrier into the network, waits for the matching wake/error (or
// the watchdog), then returns the response to that requester.
module fractal_sync_cu_arbiter
  import fractal_sync_pkg::*;
#(
  parameter  int          N_REQ          = 4,
  parameter  int          AGGR_W         = 3,
  parameter  int          LVL_W          = 1,
  parameter  int          ID_W           = 2,
  parameter  int unsigned TIMEOUT_CYCLES = FSYNC_ARB_TIMEOUT,
  localparam int          PTR_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*AGGR_W-1:0] req_aggr_i,
  input  logic [N_REQ*ID_W-1:0]   req_id_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [LVL_W-1:0]        rsp_lvl_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic                    rsp_error_o,
  output logic                    rsp_timeout_o,
  fractal_sync_cu_arbiter_if.master fsync,
  output logic                    busy_o
);

  localparam int          WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  fsync_arb_state_e r_state, w_next;

  logic [PTR_W-1:0]  r_owner;
  logic [AGGR_W-1:0] r_aggr;
  logic [ID_W-1:0]   r_id;
  logic [WD_W-1:0]   r_wd;
  logic [LVL_W-1:0]  r_rsp_lvl;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_err;
  logic              r_rsp_to;

  logic [N_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]  w_idx;
  logic              w_found;
  logic              w_match;
  logic              w_expire;
  logic              w_in_resp;

  fractal_sync_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_valid   (req_valid_i),
    .i_upd_en  (w_in_resp),
    .i_upd_idx (r_owner),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_found   (w_found)
  );

  assign w_in_resp = (r_state == ST_RESP);
  assign w_match   = (fsync.fsync_wake_i | fsync.fsync_error_i) && (fsync.fsync_id_i == r_id);
  // The count reaching the limit happens on the last WAIT cycle, so compare against limit-1.
  assign w_expire  = (TIMEOUT_CYCLES != 0) && (r_wd >= WD_W'(WD_LAST));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a match beats watchdog expiry in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_match || w_expire) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request latches, watchdog and captured response fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner   <= '0;
      r_aggr    <= '0;
      r_id      <= '0;
      r_wd      <= '0;
      r_rsp_lvl <= '0;
      r_rsp_id  <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_to  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_idx;
            r_aggr  <= req_aggr_i[w_idx*AGGR_W +: AGGR_W];
            r_id    <= req_id_i[w_idx*ID_W +: ID_W];
          end
        end
        ST_ISSUE: begin
          r_wd <= '0;
        end
        ST_WAIT: begin
          if (r_wd != {WD_W{1'b1}}) begin
            r_wd <= r_wd + 1'b1;
          end
          if (w_match) begin
            r_rsp_lvl <= fsync.fsync_lvl_i;
            r_rsp_id  <= fsync.fsync_id_i;
            r_rsp_err <= fsync.fsync_error_i;
            r_rsp_to  <= 1'b0;
          end else if (w_expire) begin
            r_rsp_lvl <= '0;
            r_rsp_id  <= r_id;
            r_rsp_err <= 1'b1;
            r_rsp_to  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response strobe to the owner only in RESP; the shared bus is zero otherwise.
  always_comb begin
    rsp_valid_o   = '0;
    rsp_lvl_o     = '0;
    rsp_id_o      = '0;
    rsp_error_o   = 1'b0;
    rsp_timeout_o = 1'b0;
    if (w_in_resp) begin
      rsp_valid_o[r_owner] = 1'b1;
      rsp_lvl_o            = r_rsp_lvl;
      rsp_id_o             = r_rsp_id;
      rsp_error_o          = r_rsp_err;
      rsp_timeout_o        = r_rsp_to;
    end
  end

  assign req_ready_o        = (r_state == ST_IDLE) ? w_grant : '0;
  assign fsync.fsync_sync_o = (r_state == ST_ISSUE);
  assign fsync.fsync_aggr_o = (r_state != ST_IDLE) ? r_aggr : '0;
  assign fsync.fsync_id_o   = (r_state != ST_IDLE) ? r_id : '0;
  assign busy_o             = (r_state != ST_IDLE);

endmodule
